// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle sequencer for the nRisc datapath with req/ack memory handshake,
// halt on encerra, memory-timeout error and retired-instruction counter.
module controle_multiciclo #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [2:0]       Istrc,
    input  logic             Zero,
    input  logic             MemAck,
    output logic             MemReq,
    output logic             MemSel,
    output logic             MemWe,
    output logic             IREscreve,
    output logic             PCEscreve,
    output logic [1:0]       PCSrc,
    output logic             RegEscreve,
    output logic             MemtoReg,
    output logic             Defi,
    output logic             OpULA,
    output logic             ULASrc,
    output logic             Encerrado,
    output logic             MemErro,
    output logic [CNT_W-1:0] Retirados
);
    typedef enum logic [2:0] {INICIO, BUSCA, DECOD, EXEC, MEM, ESCRITA, FIM, ERRO} state_t;
    localparam logic [2:0] OP_DEFI = 3'b000, OP_BEQ = 3'b001, OP_LW = 3'b010, OP_SW = 3'b011,
                           OP_MUL = 3'b100, OP_J = 3'b110, OP_FIM = 3'b111;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= INICIO;
            op_q    <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        MemReq     = 1'b0;
        MemSel     = 1'b0;
        MemWe      = 1'b0;
        IREscreve  = 1'b0;
        PCEscreve  = 1'b0;
        PCSrc      = 2'd0;
        RegEscreve = 1'b0;
        MemtoReg   = 1'b0;
        Defi       = 1'b0;
        OpULA      = 1'b0;
        ULASrc     = 1'b0;
        case (state_q)
            INICIO: state_d = BUSCA;
            BUSCA: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    IREscreve = 1'b1;
                    PCEscreve = 1'b1;
                    state_d   = DECOD;
                end
            end
            DECOD: begin
                op_d = Istrc;
                if (Istrc == OP_FIM) state_d = FIM;
                else if (Istrc == OP_J) begin
                    PCEscreve = 1'b1;
                    PCSrc     = 2'd2;
                    state_d   = BUSCA;
                end else state_d = EXEC;
            end
            EXEC: begin
                ULASrc = op_q == OP_BEQ || op_q == OP_MUL;
                OpULA  = op_q == OP_MUL;
                if (op_q == OP_BEQ) begin
                    PCEscreve = Zero;
                    PCSrc     = 2'd1;
                    state_d   = BUSCA;
                end else state_d = (op_q == OP_LW || op_q == OP_SW) ? MEM : ESCRITA;
            end
            MEM: begin
                MemReq = 1'b1;
                MemSel = 1'b1;
                MemWe  = op_q == OP_SW;
                if (MemAck) state_d = op_q == OP_SW ? BUSCA : ESCRITA;
            end
            ESCRITA: begin
                RegEscreve = 1'b1;
                MemtoReg   = op_q == OP_LW;
                Defi       = op_q == OP_DEFI;
                OpULA      = op_q == OP_MUL;
                ULASrc     = op_q == OP_MUL;
                state_d    = BUSCA;
            end
            default: state_d = state_q;
        endcase
        // the timer is only nonzero while a request is outstanding; an ack in the last cycle wins
        if (TIMEOUT > 0 && MemReq && !MemAck && timer_q == TW'(TIMEOUT - 1)) state_d = ERRO;
        timer_d = (MemReq && !MemAck) ? timer_q + 1'b1 : '0;
        retire  = (state_d == BUSCA && state_q != INICIO && state_q != BUSCA) ||
                  (state_q == DECOD && state_d == FIM);
        cnt_d   = cnt_q + CNT_W'(retire);
    end

    assign Encerrado = state_q == FIM;
    assign MemErro   = state_q == ERRO;
    assign Retirados = cnt_q;
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: directed per-cycle vectors with a queue-based scoreboard;
// the monitor pops one expected output snapshot per cycle and compares it.
module tb_controle_multiciclo;
    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic [2:0]  Istrc = '0;
    logic        Zero = 1'b0;
    logic        MemAck = 1'b0;
    logic        MemReq, MemSel, MemWe, IREscreve, PCEscreve, RegEscreve;
    logic        MemtoReg, Defi, OpULA, ULASrc, Encerrado, MemErro;
    logic [1:0]  PCSrc;
    logic [15:0] Retirados;

    controle_multiciclo dut (
        .Clock(Clock), .ResetN(ResetN), .Istrc(Istrc), .Zero(Zero), .MemAck(MemAck),
        .MemReq(MemReq), .MemSel(MemSel), .MemWe(MemWe), .IREscreve(IREscreve),
        .PCEscreve(PCEscreve), .PCSrc(PCSrc), .RegEscreve(RegEscreve), .MemtoReg(MemtoReg),
        .Defi(Defi), .OpULA(OpULA), .ULASrc(ULASrc), .Encerrado(Encerrado),
        .MemErro(MemErro), .Retirados(Retirados)
    );

    always #5 Clock = ~Clock;

    // output vector bits: req sel we ir pc src[1:0] rw m2r defi op ulas enc err
    localparam logic [13:0] Z = 14'h0000, R = 14'h2000, S = 14'h1000, W = 14'h0800,
                            I = 14'h0400, P = 14'h0200, J2 = 14'h0100, B1 = 14'h0080,
                            RW = 14'h0040, MR = 14'h0020, DF = 14'h0010, OP = 14'h0008,
                            US = 14'h0004, EN = 14'h0002, ER = 14'h0001;
    localparam logic [13:0] RIP = R | I | P;

    typedef struct packed {
        logic [13:0] v;
        logic [15:0] r;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  done = 1'b0;

    task automatic step(input logic rn, input logic [2:0] is, input logic z, input logic a,
                        input logic [13:0] e, input logic [15:0] ret, input string nm);
        @(posedge Clock);
        #1;
        ResetN = rn;
        Istrc  = is;
        Zero   = z;
        MemAck = a;
        exp_q.push_back('{v: e, r: ret});
        nm_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        logic [13:0] act;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = nm_q.pop_front();
                act = {MemReq, MemSel, MemWe, IREscreve, PCEscreve, PCSrc, RegEscreve,
                       MemtoReg, Defi, OpULA, ULASrc, Encerrado, MemErro};
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s outputs: got %b expected %b", nm, act, e.v);
                end
                n_cmp++;
                if (Retirados !== e.r) begin
                    n_bad++;
                    $display("FAIL %s Retirados: got %0d expected %0d", nm, Retirados, e.r);
                end
            end
        end
    end

    initial begin : stim
        // reset, then defi with ack held high
        step(0, 3'b000, 0, 1, Z, 0, "reset");
        step(1, 3'b000, 0, 1, Z, 0, "inicio");
        step(1, 3'b000, 0, 1, RIP, 0, "defi busca");
        step(1, 3'b000, 0, 1, Z, 0, "defi decod");
        step(1, 3'b000, 0, 1, Z, 0, "defi exec");
        step(1, 3'b000, 0, 1, RW | DF, 0, "defi escrita");
        // lw with three wait cycles in MEM
        step(1, 3'b010, 0, 1, RIP, 1, "lw busca");
        step(1, 3'b010, 0, 1, Z, 1, "lw decod");
        step(1, 3'b010, 0, 1, Z, 1, "lw exec");
        for (int k = 0; k < 3; k++) step(1, 3'b010, 0, 0, R | S, 1, "lw mem wait");
        step(1, 3'b010, 0, 1, R | S, 1, "lw mem ack");
        step(1, 3'b010, 0, 0, RW | MR, 1, "lw escrita");
        // beq taken then not taken
        step(1, 3'b001, 1, 1, RIP, 2, "beq1 busca");
        step(1, 3'b001, 1, 1, Z, 2, "beq1 decod");
        step(1, 3'b001, 1, 1, US | P | B1, 2, "beq1 exec");
        step(1, 3'b001, 0, 1, RIP, 3, "beq0 busca");
        step(1, 3'b001, 0, 1, Z, 3, "beq0 decod");
        step(1, 3'b001, 0, 1, US | B1, 3, "beq0 exec");
        // mul, subi, sw
        step(1, 3'b100, 0, 1, RIP, 4, "mul busca");
        step(1, 3'b100, 0, 1, Z, 4, "mul decod");
        step(1, 3'b100, 0, 1, US | OP, 4, "mul exec");
        step(1, 3'b100, 0, 1, RW | OP | US, 4, "mul escrita");
        step(1, 3'b101, 0, 1, RIP, 5, "subi busca");
        step(1, 3'b101, 0, 1, Z, 5, "subi decod");
        step(1, 3'b101, 0, 1, Z, 5, "subi exec");
        step(1, 3'b101, 0, 1, RW, 5, "subi escrita");
        step(1, 3'b011, 0, 1, RIP, 6, "sw busca");
        step(1, 3'b011, 0, 1, Z, 6, "sw decod");
        step(1, 3'b011, 0, 1, Z, 6, "sw exec");
        step(1, 3'b011, 0, 1, R | S | W, 6, "sw mem");
        // fetch timeout: 16 unanswered request cycles
        for (int k = 0; k < 16; k++) step(1, 3'b000, 0, 0, R, 7, "timeout wait");
        step(1, 3'b000, 0, 0, ER, 7, "erro");
        step(1, 3'b000, 0, 1, ER, 7, "erro absorbing");
        // reset, ack on 16th cycle, then j and encerra
        step(0, 3'b000, 0, 0, Z, 0, "reset2");
        step(1, 3'b000, 0, 0, Z, 0, "inicio2");
        for (int k = 0; k < 15; k++) step(1, 3'b110, 0, 0, R, 0, "late ack wait");
        step(1, 3'b110, 0, 1, RIP, 0, "late ack");
        step(1, 3'b110, 0, 0, P | J2, 0, "j decod");
        step(1, 3'b111, 0, 1, RIP, 1, "fim busca");
        step(1, 3'b111, 0, 1, Z, 1, "fim decod");
        step(1, 3'b111, 0, 1, EN, 2, "fim");
        step(1, 3'b000, 0, 1, EN, 2, "fim absorbing");
        // asynchronous reset in the middle of a sw memory access
        step(0, 3'b000, 0, 0, Z, 0, "reset3");
        step(1, 3'b011, 0, 1, Z, 0, "inicio3");
        step(1, 3'b011, 0, 1, RIP, 0, "sw2 busca");
        step(1, 3'b011, 0, 1, Z, 0, "sw2 decod");
        step(1, 3'b011, 0, 0, Z, 0, "sw2 exec");
        step(1, 3'b011, 0, 0, R | S | W, 0, "sw2 mem");
        step(0, 3'b011, 0, 0, Z, 0, "async reset in mem");
        step(1, 3'b000, 0, 0, Z, 0, "inicio4");
        step(1, 3'b000, 0, 0, R, 0, "refetch");
        step(1, 3'b000, 0, 1, RIP, 0, "refetch ack");
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clock);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        done = 1'b1;
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
        end
    end
endmodule
